// File: rtl/mem_stage.sv
// mem_stage: MEM-stage datapath fed by the EX/MEM register.
// Holds the byte-addressable little-endian data memory, narrow load extension,
// branch/jr resolution into PCSrc/Flush, and the architectural HI/LO pair.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN. When defined, misaligned
// word/half accesses are suppressed and latch a sticky error flag. When undefined,
// they are forced to their aligned address and the flag reads 0.
module mem_stage #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] MemDataIn,
    input  logic        MemWriteIn,
    input  logic        MemReadIn,
    input  logic [1:0]  dataTypeIn,
    input  logic [1:0]  BranchIn,
    input  logic        ZeroIn,
    input  logic [31:0] BranchAddResultIn,
    input  logic [31:0] ReadData1In,
    input  logic [63:0] MultResultIn,
    input  logic        MultBitIn,
    input  logic        HiLoWriteIn,
    output logic [31:0] ReadDataOut,
    output logic        PCSrcOut,
    output logic [31:0] BranchTargetOut,
    output logic        FlushOut,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        MisalignErrOut
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] DT_WORD  = 2'b00;
    localparam logic [1:0] DT_HALF  = 2'b01;
    localparam logic [1:0] DT_BYTES = 2'b10;
    localparam logic [1:0] DT_BYTEU = 2'b11;

    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;
    localparam logic [1:0] BR_JR  = 2'b11;

    logic [31:0]   mem_q [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   load_data;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [63:0]   hilo_q;
    logic [63:0]   hilo_d;
    logic          unused_addr_hi;

    // Upper address bits beyond the memory depth are deliberately dropped (wrap).
    assign unused_addr_hi = ^ALUResultIn[31:AW+2];

    assign word_idx = ALUResultIn[AW+1:2];
    assign lane     = ALUResultIn[1:0];
    assign rd_word  = mem_q[word_idx];

    // Decode access size into store byte enables/data and the extended load value.
    always_comb begin
        wr_be     = 4'b0000;
        wr_data   = MemDataIn;
        load_data = 32'h0;
        half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        case (dataTypeIn)
            DT_WORD: begin
                wr_be     = 4'b1111;
                wr_data   = MemDataIn;
                load_data = rd_word;
            end
            DT_HALF: begin
                wr_be     = lane[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{MemDataIn[15:0]}};
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            DT_BYTES: begin
                wr_be     = 4'b0001 << lane;
                wr_data   = {4{MemDataIn[7:0]}};
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            default: begin
                wr_be     = 4'b0001 << lane;
                wr_data   = {4{MemDataIn[7:0]}};
                load_data = {24'h0, byte_sel};
            end
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misalign;
    logic err_q;
    logic err_d;
    logic [3:0]  wr_be_eff;
    logic [31:0] load_eff;

    // Flag misaligned word/half accesses, squash them, and accumulate the sticky error.
    always_comb begin
        misalign  = ((dataTypeIn == DT_WORD) && (lane != 2'b00)) ||
                    ((dataTypeIn == DT_HALF) && lane[0]);
        wr_be_eff = misalign ? 4'b0000 : wr_be;
        load_eff  = misalign ? 32'h0 : load_data;
        err_d     = err_q | ((MemWriteIn | MemReadIn) & misalign);
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign MisalignErrOut = err_q;
`else
    logic [3:0]  wr_be_eff;
    logic [31:0] load_eff;

    assign wr_be_eff      = wr_be;
    assign load_eff       = load_data;
    assign MisalignErrOut = 1'b0;
`endif

    // Data memory write port; not reset, and writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && MemWriteIn) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_eff[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign ReadDataOut = MemReadIn ? load_eff : 32'h0;

    // Branch/jr resolution; a taken redirect also flushes the younger stages.
    always_comb begin
        PCSrcOut = ((BranchIn == BR_BEQ) &&  ZeroIn) ||
                   ((BranchIn == BR_BNE) && !ZeroIn) ||
                    (BranchIn == BR_JR);
        BranchTargetOut = (BranchIn == BR_JR) ? ReadData1In : BranchAddResultIn;
        FlushOut        = PCSrcOut;
    end

    // Next HI/LO: load the product for mult, accumulate it (mod 2^64) for madd.
    always_comb begin
        hilo_d = hilo_q;
        if (HiLoWriteIn) begin
            hilo_d = MultBitIn ? MultResultIn : (hilo_q + MultResultIn);
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hilo_q <= 64'h0;
        end else begin
            hilo_q <= hilo_d;
        end
    end

    assign HiOut = hilo_q[63:32];
    assign LoOut = hilo_q[31:0];

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage.
// Stimulus pushes hand-computed expectations; the monitor pops and compares
// them on the falling edge of the same cycle.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUResultIn;
    logic [31:0] MemDataIn;
    logic        MemWriteIn;
    logic        MemReadIn;
    logic [1:0]  dataTypeIn;
    logic [1:0]  BranchIn;
    logic        ZeroIn;
    logic [31:0] BranchAddResultIn;
    logic [31:0] ReadData1In;
    logic [63:0] MultResultIn;
    logic        MultBitIn;
    logic        HiLoWriteIn;
    logic [31:0] ReadDataOut;
    logic        PCSrcOut;
    logic [31:0] BranchTargetOut;
    logic        FlushOut;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        MisalignErrOut;

    typedef enum int {SEL_RD, SEL_PCSRC, SEL_TGT, SEL_FLUSH, SEL_HI, SEL_LO, SEL_MIS} sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } expect_t;

    expect_t sb[$];
    int      checks;
    int      errors;

    mem_stage #(.MEM_WORDS(1024)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ALUResultIn       (ALUResultIn),
        .MemDataIn         (MemDataIn),
        .MemWriteIn        (MemWriteIn),
        .MemReadIn         (MemReadIn),
        .dataTypeIn        (dataTypeIn),
        .BranchIn          (BranchIn),
        .ZeroIn            (ZeroIn),
        .BranchAddResultIn (BranchAddResultIn),
        .ReadData1In       (ReadData1In),
        .MultResultIn      (MultResultIn),
        .MultBitIn         (MultBitIn),
        .HiLoWriteIn       (HiLoWriteIn),
        .ReadDataOut       (ReadDataOut),
        .PCSrcOut          (PCSrcOut),
        .BranchTargetOut   (BranchTargetOut),
        .FlushOut          (FlushOut),
        .HiOut             (HiOut),
        .LoOut             (LoOut),
        .MisalignErrOut    (MisalignErrOut)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] actualOf(input sel_e s);
        case (s)
            SEL_RD:    return ReadDataOut;
            SEL_PCSRC: return {31'h0, PCSrcOut};
            SEL_TGT:   return BranchTargetOut;
            SEL_FLUSH: return {31'h0, FlushOut};
            SEL_HI:    return HiOut;
            SEL_LO:    return LoOut;
            default:   return {31'h0, MisalignErrOut};
        endcase
    endfunction

    // Monitor: drain every expectation queued for this cycle on the falling edge.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                expect_t e;
                logic [31:0] act;
                e   = sb.pop_front();
                act = actualOf(e.sel);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic idle();
        MemWriteIn        = 1'b0;
        MemReadIn         = 1'b0;
        dataTypeIn        = 2'b00;
        ALUResultIn       = 32'h0;
        MemDataIn         = 32'h0;
        BranchIn          = 2'b00;
        ZeroIn            = 1'b0;
        BranchAddResultIn = 32'h0;
        ReadData1In       = 32'h0;
        MultResultIn      = 64'h0;
        MultBitIn         = 1'b0;
        HiLoWriteIn       = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic re, input logic [1:0] dt,
                                 input logic [31:0] addr, input logic [31:0] data);
        idle();
        MemWriteIn  = we;
        MemReadIn   = re;
        dataTypeIn  = dt;
        ALUResultIn = addr;
        MemDataIn   = data;
    endtask

    task automatic applyBranch(input logic [1:0] br, input logic z,
                               input logic [31:0] badd, input logic [31:0] rd1);
        idle();
        BranchIn          = br;
        ZeroIn            = z;
        BranchAddResultIn = badd;
        ReadData1In       = rd1;
    endtask

    task automatic applyHiLo(input logic wr, input logic mb, input logic [63:0] prod);
        idle();
        HiLoWriteIn  = wr;
        MultBitIn    = mb;
        MultResultIn = prod;
    endtask

    task automatic checkOutput(input sel_e s, input logic [31:0] exp, input string name);
        expect_t e;
        e.name = name;
        e.sel  = s;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        applyHiLo(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        step();
        checkOutput(SEL_HI, 32'h0, "reset_hi");
        checkOutput(SEL_LO, 32'h0, "reset_lo");
        checkOutput(SEL_MIS, 32'h0, "reset_misalign");

        // Release reset and store a word.
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h10, 32'h1234_5678);
        checkOutput(SEL_RD, 32'h0, "rd_zero_when_no_read");
        step();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
        checkOutput(SEL_RD, 32'h1234_5678, "lw_0x10");
        step();

        // Narrow accesses.
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h11, 32'hFFFF_FFAB);
        step();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
        checkOutput(SEL_RD, 32'h1234_AB78, "lw_after_sb");
        step();
        applyStimulus(1'b0, 1'b1, 2'b10, 32'h11, 32'h0);
        checkOutput(SEL_RD, 32'hFFFF_FFAB, "lb_0x11");
        step();
        applyStimulus(1'b0, 1'b1, 2'b11, 32'h11, 32'h0);
        checkOutput(SEL_RD, 32'h0000_00AB, "lbu_0x11");
        step();
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h12, 32'h0);
        checkOutput(SEL_RD, 32'h0000_1234, "lh_0x12");
        step();
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h10, 32'h0);
        checkOutput(SEL_RD, 32'hFFFF_AB78, "lh_0x10_neg");
        step();
        applyStimulus(1'b0, 1'b1, 2'b11, 32'h13, 32'h0);
        checkOutput(SEL_RD, 32'h0000_0012, "lbu_0x13");
        step();
        applyStimulus(1'b1, 1'b0, 2'b01, 32'h12, 32'hCAFE_BEEF);
        step();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
        checkOutput(SEL_RD, 32'hBEEF_AB78, "lw_after_sh");
        step();

        // Branch resolution.
        applyBranch(2'b01, 1'b1, 32'h40, 32'h80);
        checkOutput(SEL_PCSRC, 32'h1, "beq_taken_pcsrc");
        checkOutput(SEL_FLUSH, 32'h1, "beq_taken_flush");
        checkOutput(SEL_TGT, 32'h40, "beq_target");
        step();
        applyBranch(2'b01, 1'b0, 32'h40, 32'h80);
        checkOutput(SEL_PCSRC, 32'h0, "beq_not_taken");
        step();
        applyBranch(2'b10, 1'b1, 32'h40, 32'h80);
        checkOutput(SEL_PCSRC, 32'h0, "bne_not_taken");
        checkOutput(SEL_FLUSH, 32'h0, "bne_not_taken_flush");
        step();
        applyBranch(2'b10, 1'b0, 32'h44, 32'h80);
        checkOutput(SEL_PCSRC, 32'h1, "bne_taken");
        checkOutput(SEL_TGT, 32'h44, "bne_target");
        step();
        applyBranch(2'b11, 1'b1, 32'h40, 32'h80);
        checkOutput(SEL_PCSRC, 32'h1, "jr_taken");
        checkOutput(SEL_TGT, 32'h80, "jr_target");
        step();
        applyBranch(2'b00, 1'b1, 32'h40, 32'h80);
        checkOutput(SEL_PCSRC, 32'h0, "nobranch_pcsrc");
        checkOutput(SEL_TGT, 32'h40, "nobranch_target");
        step();

        // HI/LO mult and madd.
        applyHiLo(1'b1, 1'b1, 64'h0000_0001_FFFF_FFFF);
        step();
        applyHiLo(1'b1, 1'b0, 64'h1);
        checkOutput(SEL_HI, 32'h1, "mult_hi");
        checkOutput(SEL_LO, 32'hFFFF_FFFF, "mult_lo");
        step();
        applyHiLo(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput(SEL_HI, 32'h2, "madd1_hi");
        checkOutput(SEL_LO, 32'h0, "madd1_lo");
        step();
        applyHiLo(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0);
        checkOutput(SEL_HI, 32'h1, "madd_wrap_hi");
        checkOutput(SEL_LO, 32'hFFFF_FFFF, "madd_wrap_lo");
        step();
        idle();
        checkOutput(SEL_HI, 32'h1, "hold_hi");
        checkOutput(SEL_LO, 32'hFFFF_FFFF, "hold_lo");
        step();

        // Address wrap and read-during-write.
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h1000, 32'h0BAD_F00D);
        step();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        checkOutput(SEL_RD, 32'h0BAD_F00D, "wrap_load_0x0");
        step();
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h0, 32'h1111_2222);
        checkOutput(SEL_RD, 32'h0BAD_F00D, "rdw_old_data");
        step();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        checkOutput(SEL_RD, 32'h1111_2222, "rdw_new_data");
        step();

        // Misaligned word store at 0x13 over word 0xBEEFAB78 at 0x10.
        applyStimulus(1'b1, 1'b0, 2'b00, 32'h13, 32'hA5A5_A5A5);
        step();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h10, 32'h0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        checkOutput(SEL_RD, 32'hBEEF_AB78, "misaligned_store_suppressed");
        checkOutput(SEL_MIS, 32'h1, "misalign_flag_set");
`else
        checkOutput(SEL_RD, 32'hA5A5_A5A5, "misaligned_store_forced");
        checkOutput(SEL_MIS, 32'h0, "misalign_flag_tied");
`endif
        step();
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h13, 32'h0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        checkOutput(SEL_RD, 32'h0, "misaligned_load_zero");
        checkOutput(SEL_MIS, 32'h1, "misalign_flag_sticky");
`else
        checkOutput(SEL_RD, 32'hA5A5_A5A5, "misaligned_load_forced");
        checkOutput(SEL_MIS, 32'h0, "misalign_flag_still_0");
`endif
        step();

        // Asynchronous reset mid-cycle clears state before the next edge.
        idle();
        rst_n = 1'b0;
        #1;
        checkOutput(SEL_HI, 32'h0, "async_reset_hi");
        checkOutput(SEL_LO, 32'h0, "async_reset_lo");
        checkOutput(SEL_MIS, 32'h0, "async_reset_misalign");
        step();
        step();

        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
